branch_cond_unit: RTL

Registered conditional-branch resolver for the datapath control path, the next generation of the CON flip-flop. Evaluates an extended set of branch conditions on a parametrised-width register operand using signed two's-complement arithmetic. Holds the taken/not-taken result under a valid/ack handshake until the control unit consumes it. Keeps saturating statistics counters for evaluated and taken branches.

---
 rtl/branch_pkg.sv | 27 ++
 rtl/branch_cond_eval.sv | 42 ++++
 rtl/branch_cond_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared condition codes, field width and FSM states for the
//               conditional-branch resolver.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam int COND_W = 4;

    localparam logic [COND_W-1:0] BRZR = 4'b0000;
    localparam logic [COND_W-1:0] BRNZ = 4'b0001;
    localparam logic [COND_W-1:0] BRPL = 4'b0010;
    localparam logic [COND_W-1:0] BRMI = 4'b0011;
    localparam logic [COND_W-1:0] BRGE = 4'b0100;
    localparam logic [COND_W-1:0] BRLE = 4'b0101;
    localparam logic [COND_W-1:0] BRAL = 4'b0110;
    localparam logic [COND_W-1:0] BRNV = 4'b0111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_eval
// Description : Combinational branch-condition decoder on a signed operand.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] d,
    input  logic [COND_W-1:0] code,
    output logic              taken,
    output logic              legal
);

    logic w_zero;
    logic w_neg;

    // Sign decisions come from the MSB alone; zero is a full-width test.
    assign w_zero = (d == '0);
    assign w_neg  = d[DATA_W-1];

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (code)
            BRZR:    taken = w_zero;
            BRNZ:    taken = ~w_zero;
            BRPL:    taken = ~w_neg & ~w_zero;
            BRMI:    taken = w_neg;
            BRGE:    taken = ~w_neg;
            BRLE:    taken = w_neg | w_zero;
            BRAL:    taken = 1'b1;
            BRNV:    taken = 1'b0;
            default: legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_unit
// Description : Registered branch resolver with valid/ack hold and saturating
//               evaluation/taken statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_unit
    import branch_pkg::*;
#(
    parameter int   DATA_W   = 32,
    parameter int   COND_LSB = 19,
    parameter int   CNT_W    = 16,
    parameter logic RESET_Q  = 1'b0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              con_in,
    input  logic [31:0]       ir,
    input  logic [DATA_W-1:0] d,
    input  logic              con_ack,
    output logic              con_out,
    output logic              con_valid,
    output logic              cond_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  eval_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    state_t             r_state;
    logic               r_con_out;
    logic               r_con_valid;
    logic               r_cond_err;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_eval_cnt;
    logic [CNT_W-1:0]   r_taken_cnt;

    state_t             w_state_nxt;
    logic               w_out_nxt;
    logic               w_valid_nxt;
    logic               w_err_nxt;
    logic               w_ovr_nxt;
    logic               w_load;
    logic [CNT_W-1:0]   w_eval_nxt;
    logic [CNT_W-1:0]   w_taken_nxt;

    logic [COND_W-1:0]  w_code;
    logic               w_taken;
    logic               w_legal;
    logic               w_unused_ir;

    assign w_code      = ir[COND_LSB +: COND_W];
    assign w_unused_ir = ^ir;

    branch_cond_eval #(
        .DATA_W (DATA_W)
    ) u_eval (
        .d      (d),
        .code   (w_code),
        .taken  (w_taken),
        .legal  (w_legal)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_con_valid;
        w_err_nxt   = 1'b0;
        w_ovr_nxt   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (con_in) begin
                    if (w_legal) begin
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (con_ack) begin
                    if (con_in && w_legal) begin
                        w_load      = 1'b1;
                    end else begin
                        // An illegal strobe alongside ack still releases the result.
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                        w_err_nxt   = con_in;
                    end
                end else if (con_in) begin
                    w_ovr_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        w_out_nxt   = w_load ? w_taken : r_con_out;
        w_eval_nxt  = r_eval_cnt;
        w_taken_nxt = r_taken_cnt;
        if (w_load && (r_eval_cnt != '1))
            w_eval_nxt = r_eval_cnt + 1'b1;
        if (w_load && w_taken && (r_taken_cnt != '1))
            w_taken_nxt = r_taken_cnt + 1'b1;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state     <= IDLE;
            r_con_out   <= RESET_Q;
            r_con_valid <= 1'b0;
            r_cond_err  <= 1'b0;
            r_overrun   <= 1'b0;
            r_eval_cnt  <= '0;
            r_taken_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_con_out   <= w_out_nxt;
            r_con_valid <= w_valid_nxt;
            r_cond_err  <= w_err_nxt;
            r_overrun   <= w_ovr_nxt;
            r_eval_cnt  <= w_eval_nxt;
            r_taken_cnt <= w_taken_nxt;
        end
    end

    assign con_out   = r_con_out;
    assign con_valid = r_con_valid;
    assign cond_err  = r_cond_err;
    assign overrun   = r_overrun;
    assign eval_cnt  = r_eval_cnt;
    assign taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire
